// File: rtl/key_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_conditioner_if
//  Purpose  : Bundles the raw push-button bus and the conditioned key outputs
//             exchanged between the board pins and the game core.
//  Signals  : Key      [3:0]  raw buttons, active-low ([3]=Up,[2]=Down,
//                             [1]=Left,[0]=Right)
//             Key_db   [3:0]  debounced keys, active-low, same mapping
//             Press    [3:0]  one-cycle active-high press pulses
//             Dir      [3:0]  one-hot last-pressed direction (0000 = none)
//             Any_held        high while any debounced key is down
//  Modports : master - drives Key, observes the conditioned outputs
//             slave  - the conditioner itself
//  Revision : 1.0  initial release
// ============================================================================
interface key_conditioner_if;
  logic [3:0] Key;
  logic [3:0] Key_db;
  logic [3:0] Press;
  logic [3:0] Dir;
  logic       Any_held;

  modport master (
    output Key,
    input  Key_db,
    input  Press,
    input  Dir,
    input  Any_held
  );

  modport slave (
    input  Key,
    output Key_db,
    output Press,
    output Dir,
    output Any_held
  );
endinterface
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : key_conditioner
//  Purpose  : Synchronises and debounces four active-low push-buttons, emits
//             one-cycle press pulses and latches a one-hot last direction.
//  Ports    : Clk_50MHz  system clock (only clock)
//             Rst_n      asynchronous active-low reset
//             kif        key_conditioner_if.slave (Key in; Key_db, Press,
//                        Dir, Any_held out)
//  Options  : KEYCOND_REPEAT_EN - when defined, the key selected by Dir
//             auto-repeats its Press pulse after REPEAT_DELAY cycles and
//             then every REPEAT_PERIOD cycles while it stays held.
//  Revision : 1.0  initial release
// ============================================================================
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 6250000
) (
  input  logic                 Clk_50MHz,
  input  logic                 Rst_n,
  key_conditioner_if.slave     kif
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [3:0]       key_db_q, key_db_d;
  logic [3:0]       key_db_dly_q, key_db_dly_d;
  logic             any_held_q, any_held_d;
  logic [3:0]       press_q, press_d;
  logic [3:0]       dir_q, dir_d;
  logic [3:0]       fall;
  logic [3:0]       rpt_pulse;

  // Two-flop synchroniser; only sync2_q is used downstream.
  assign sync1_d = kif.Key;
  assign sync2_d = sync1_q;

  // Per-key debounce: any cycle where the synced level matches the stable
  // level restarts the count, so only an uninterrupted run is accepted.
  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == key_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        key_db_d[i] = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign key_db_dly_d = key_db_q;
  assign any_held_d   = ~&key_db_d;

  // Falling edge of the debounced level, seen one cycle after Key_db drops.
  assign fall = key_db_dly_q & ~key_db_q;

  // Direction arbitration: Right > Left > Down > Up.
  always_comb begin
    dir_d = dir_q;
    if (fall[0])      dir_d = 4'b0001;
    else if (fall[1]) dir_d = 4'b0010;
    else if (fall[2]) dir_d = 4'b0100;
    else if (fall[3]) dir_d = 4'b1000;
  end

  assign press_d = fall | rpt_pulse;

`ifdef KEYCOND_REPEAT_EN
  // Counter is sized from the repeat intervals themselves so the default
  // multi-second delays fit regardless of the debounce counter width.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;   // 0: awaiting first repeat
  logic             dir_held;

  assign dir_held = (dir_q != 4'b0000) && ((key_db_q & dir_q) == 4'b0000);

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_pulse   = 4'b0000;
    if (|fall || !dir_held) begin
      // A genuine press restarts the delay; a release stops repeating.
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (!rpt_phase_q && rpt_cnt_q == RPT_DELAY_LAST) begin
      rpt_pulse   = dir_q;
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b1;
    end else if (rpt_phase_q && rpt_cnt_q == RPT_PERIOD_LAST) begin
      rpt_pulse   = dir_q;
      rpt_cnt_d   = '0;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rpt_pulse = 4'b0000;
`endif

  always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      key_db_q     <= 4'b1111;
      key_db_dly_q <= 4'b1111;
      any_held_q   <= 1'b0;
      press_q      <= 4'b0000;
      dir_q        <= 4'b0000;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_dly_d;
      any_held_q   <= any_held_d;
      press_q      <= press_d;
      dir_q        <= dir_d;
    end
  end

  assign kif.Key_db   = key_db_q;
  assign kif.Press    = press_q;
  assign kif.Dir      = dir_q;
  assign kif.Any_held = any_held_q;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_conditioner
//  Purpose  : Directed self-checking bench for key_conditioner with
//             DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
//             Expected values are hand-derived: a key changed before edge n
//             reaches Key_db at edge n+5 and Press at edge n+6.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_conditioner;

  logic Clk_50MHz;
  logic Rst_n;
  int   checks;
  int   failures;

  key_conditioner_if kif ();

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .Clk_50MHz (Clk_50MHz),
    .Rst_n     (Rst_n),
    .kif       (kif)
  );

  initial begin
    Clk_50MHz = 1'b0;
    forever #5 Clk_50MHz = ~Clk_50MHz;
  end

  // Advance past the next rising edge; samples taken 1 ns after it.
  task automatic tick;
    @(posedge Clk_50MHz);
    #1;
  endtask

  task automatic test_reset;
    Rst_n   = 1'b0;
    kif.Key = 4'b1111;
    repeat (3) tick();
    checks++; if (kif.Key_db !== 4'b1111) begin failures++; $display("FAIL reset_key_db actual=%b required=1111", kif.Key_db); end
    checks++; if (kif.Press !== 4'b0000) begin failures++; $display("FAIL reset_press actual=%b required=0000", kif.Press); end
    checks++; if (kif.Dir !== 4'b0000) begin failures++; $display("FAIL reset_dir actual=%b required=0000", kif.Dir); end
    checks++; if (kif.Any_held !== 1'b0) begin failures++; $display("FAIL reset_any_held actual=%b required=0", kif.Any_held); end
    Rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_press;
    logic [3:0] e_db, e_pr, e_dir;
    kif.Key = 4'b1110;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e_db  = (t >= 6) ? 4'b1110 : 4'b1111;
      e_pr  = (t == 7) ? 4'b0001 : 4'b0000;
      e_dir = (t >= 7) ? 4'b0001 : 4'b0000;
      checks++; if (kif.Key_db !== e_db) begin failures++; $display("FAIL single_key_db t=%0d actual=%b required=%b", t, kif.Key_db, e_db); end
      checks++; if (kif.Press !== e_pr) begin failures++; $display("FAIL single_press t=%0d actual=%b required=%b", t, kif.Press, e_pr); end
      checks++; if (kif.Dir !== e_dir) begin failures++; $display("FAIL single_dir t=%0d actual=%b required=%b", t, kif.Dir, e_dir); end
      checks++; if (kif.Any_held !== (t >= 6)) begin failures++; $display("FAIL single_any_held t=%0d actual=%b required=%b", t, kif.Any_held, (t >= 6)); end
    end
  endtask

  task automatic test_glitch;
    kif.Key = 4'b1010;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 3) kif.Key = 4'b1110;
      checks++; if (kif.Key_db !== 4'b1110) begin failures++; $display("FAIL glitch_key_db t=%0d actual=%b required=1110", t, kif.Key_db); end
      checks++; if (kif.Press !== 4'b0000) begin failures++; $display("FAIL glitch_press t=%0d actual=%b required=0000", t, kif.Press); end
      checks++; if (kif.Dir !== 4'b0001) begin failures++; $display("FAIL glitch_dir t=%0d actual=%b required=0001", t, kif.Dir); end
    end
  endtask

  task automatic test_release;
    logic [3:0] e_db;
    kif.Key = 4'b1111;
    for (int t = 1; t <= 10; t++) begin
      tick();
      e_db = (t >= 6) ? 4'b1111 : 4'b1110;
      checks++; if (kif.Key_db !== e_db) begin failures++; $display("FAIL release_key_db t=%0d actual=%b required=%b", t, kif.Key_db, e_db); end
      checks++; if (kif.Press !== 4'b0000) begin failures++; $display("FAIL release_press t=%0d actual=%b required=0000", t, kif.Press); end
      checks++; if (kif.Dir !== 4'b0001) begin failures++; $display("FAIL release_dir t=%0d actual=%b required=0001", t, kif.Dir); end
      checks++; if (kif.Any_held !== (t < 6)) begin failures++; $display("FAIL release_any_held t=%0d actual=%b required=%b", t, kif.Any_held, (t < 6)); end
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] e_db, e_pr, e_dir;
    kif.Key = 4'b0101;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e_db  = (t >= 6) ? 4'b0101 : 4'b1111;
      e_pr  = (t == 7) ? 4'b1010 : 4'b0000;
      e_dir = (t >= 7) ? 4'b0010 : 4'b0001;
      checks++; if (kif.Key_db !== e_db) begin failures++; $display("FAIL simul_key_db t=%0d actual=%b required=%b", t, kif.Key_db, e_db); end
      checks++; if (kif.Press !== e_pr) begin failures++; $display("FAIL simul_press t=%0d actual=%b required=%b", t, kif.Press, e_pr); end
      checks++; if (kif.Dir !== e_dir) begin failures++; $display("FAIL simul_dir t=%0d actual=%b required=%b", t, kif.Dir, e_dir); end
    end
    kif.Key = 4'b1111;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e_db = (t >= 6) ? 4'b1111 : 4'b0101;
      checks++; if (kif.Key_db !== e_db) begin failures++; $display("FAIL simul_rel_key_db t=%0d actual=%b required=%b", t, kif.Key_db, e_db); end
      checks++; if (kif.Press !== 4'b0000) begin failures++; $display("FAIL simul_rel_press t=%0d actual=%b required=0000", t, kif.Press); end
      checks++; if (kif.Dir !== 4'b0010) begin failures++; $display("FAIL simul_rel_dir t=%0d actual=%b required=0010", t, kif.Dir); end
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [3:0] e_db, e_pr, e_dir;
    kif.Key = 4'b1110;
    repeat (8) tick();
    checks++; if (kif.Key_db !== 4'b1110) begin failures++; $display("FAIL midrst_pre_key_db actual=%b required=1110", kif.Key_db); end
    checks++; if (kif.Dir !== 4'b0001) begin failures++; $display("FAIL midrst_pre_dir actual=%b required=0001", kif.Dir); end
    // Assert reset between clock edges; outputs must clear without a clock.
    #3;
    Rst_n = 1'b0;
    #1;
    checks++; if (kif.Key_db !== 4'b1111) begin failures++; $display("FAIL async_rst_key_db actual=%b required=1111", kif.Key_db); end
    checks++; if (kif.Dir !== 4'b0000) begin failures++; $display("FAIL async_rst_dir actual=%b required=0000", kif.Dir); end
    checks++; if (kif.Any_held !== 1'b0) begin failures++; $display("FAIL async_rst_any_held actual=%b required=0", kif.Any_held); end
    checks++; if (kif.Press !== 4'b0000) begin failures++; $display("FAIL async_rst_press actual=%b required=0000", kif.Press); end
    tick();
    tick();
    checks++; if (kif.Key_db !== 4'b1111) begin failures++; $display("FAIL midrst_held_key_db actual=%b required=1111", kif.Key_db); end
    Rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e_db  = (t >= 6) ? 4'b1110 : 4'b1111;
      e_pr  = (t == 7) ? 4'b0001 : 4'b0000;
      e_dir = (t >= 7) ? 4'b0001 : 4'b0000;
      checks++; if (kif.Key_db !== e_db) begin failures++; $display("FAIL midrst_key_db t=%0d actual=%b required=%b", t, kif.Key_db, e_db); end
      checks++; if (kif.Press !== e_pr) begin failures++; $display("FAIL midrst_press t=%0d actual=%b required=%b", t, kif.Press, e_pr); end
      checks++; if (kif.Dir !== e_dir) begin failures++; $display("FAIL midrst_dir t=%0d actual=%b required=%b", t, kif.Dir, e_dir); end
    end
  endtask

  task automatic test_repeat;
    logic [3:0] e_db, e_pr, e_dir;
    logic       rep_en;
`ifdef KEYCOND_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    kif.Key = 4'b1111;
    repeat (8) tick();
    checks++; if (kif.Key_db !== 4'b1111) begin failures++; $display("FAIL repeat_idle_key_db actual=%b required=1111", kif.Key_db); end
    kif.Key = 4'b1011;
    for (int t = 1; t <= 42; t++) begin
      if (t == 31) kif.Key = 4'b1111;
      tick();
      e_db  = (t >= 6 && t < 36) ? 4'b1011 : 4'b1111;
      e_pr  = ((t == 7) || (rep_en && t >= 17 && t <= 35 && ((t - 17) % 3 == 0))) ? 4'b0100 : 4'b0000;
      e_dir = (t >= 7) ? 4'b0100 : 4'b0001;
      checks++; if (kif.Key_db !== e_db) begin failures++; $display("FAIL repeat_key_db t=%0d actual=%b required=%b", t, kif.Key_db, e_db); end
      checks++; if (kif.Press !== e_pr) begin failures++; $display("FAIL repeat_press t=%0d actual=%b required=%b", t, kif.Press, e_pr); end
      checks++; if (kif.Dir !== e_dir) begin failures++; $display("FAIL repeat_dir t=%0d actual=%b required=%b", t, kif.Dir, e_dir); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Rst_n    = 1'b0;
    kif.Key  = 4'b1111;
    test_reset();
    test_single_press();
    test_glitch();
    test_release();
    test_simultaneous();
    test_reset_mid_hold();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
